// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the requester handshake and the CDB broadcast bus of cdb_arbiter.
//
// Signals:
//   req_valid [NUM_REQ]   : requester i has a result to broadcast
//   req_pkt   [NUM_REQ]   : result packet of requester i (is_valid ignored)
//   req_ready [NUM_REQ]   : grant to requester i, same cycle as the request
//   cdb_pkt   [CDB_PORTS] : registered broadcast packets, is_valid = live slot
//
// Modports:
//   master : the result producers (drive requests, observe grants and CDB)
//   slave  : the arbiter
//
// TAG_WIDTH / CPU_DATA_BITS mirror the core-wide values of uarch_pkg and
// riscv_isa_pkg; the packet layout must stay identical to the one declared
// in cdb_arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int CDB_PORTS     = 2,
    parameter int TAG_WIDTH     = 6,
    parameter int CPU_DATA_BITS = 32
);

    typedef struct packed {
        logic                     is_valid;
        logic [TAG_WIDTH-1:0]     dest_tag;
        logic [CPU_DATA_BITS-1:0] result;
        logic                     is_exception;
    } writeback_packet_t;

    logic              [NUM_REQ-1:0]   req_valid;
    writeback_packet_t [NUM_REQ-1:0]   req_pkt;
    logic              [NUM_REQ-1:0]   req_ready;
    writeback_packet_t [CDB_PORTS-1:0] cdb_pkt;

    modport master (
        output req_valid,
        output req_pkt,
        input  req_ready,
        input  cdb_pkt
    );

    modport slave (
        input  req_valid,
        input  req_pkt,
        output req_ready,
        output cdb_pkt
    );

endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus between NUM_REQ result producers. Up to
// CDB_PORTS requesters are granted per cycle in round-robin order starting at
// the pointer; the winning packets are registered and broadcast one cycle
// later. Flush and reset block all grants.
//
// Ports:
//   clk      : core clock, rising edge
//   rst_n    : synchronous reset, active-low
//   flush    : mispredict/exception flush, suppresses grants this cycle
//   bus      : cdb_arbiter_if.slave (req_valid/req_pkt in, req_ready/cdb_pkt out)
//   rr_ptr_o : current round-robin pointer (debug)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int CDB_PORTS     = 2,
    parameter int TAG_WIDTH     = 6,
    parameter int CPU_DATA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    cdb_arbiter_if.slave               bus,
    output logic [$clog2(NUM_REQ)-1:0] rr_ptr_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Same layout as the interface packet; assignments between them are
    // plain packed-vector copies.
    typedef struct packed {
        logic                     is_valid;
        logic [TAG_WIDTH-1:0]     dest_tag;
        logic [CPU_DATA_BITS-1:0] result;
        logic                     is_exception;
    } writeback_packet_t;

    logic              [PTR_W-1:0]     rr_ptr_q;
    logic              [PTR_W-1:0]     rr_ptr_d;
    writeback_packet_t [CDB_PORTS-1:0] cdb_q;
    writeback_packet_t [CDB_PORTS-1:0] cdb_d;
    logic              [NUM_REQ-1:0]   grant_s;
    int                                pos_s  [NUM_REQ];
    int                                rank_s [NUM_REQ];
    int                                last_pos_s;

    // Scan position of each requester: distance from the pointer, modulo
    // NUM_REQ, so non-power-of-two requester counts wrap correctly.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(rr_ptr_q)) begin
                pos_s[i] = i - int'(rr_ptr_q);
            end else begin
                pos_s[i] = i + NUM_REQ - int'(rr_ptr_q);
            end
        end
    end

    // Rank = number of valid requesters ahead in scan order; the first
    // CDB_PORTS valid requesters win. Depends only on valid/pointer/flush/reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rank_s[i] = 0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (bus.req_valid[j] && (pos_s[j] < pos_s[i])) begin
                    rank_s[i] = rank_s[i] + 1;
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
            if (rst_n && !flush && bus.req_valid[i] && (rank_s[i] < CDB_PORTS)) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Route each winner to the port matching its rank, and move the pointer
    // just past the winner furthest along in scan order.
    always_comb begin
        cdb_d      = '0;
        rr_ptr_d   = rr_ptr_q;
        last_pos_s = -1;
        for (int p = 0; p < CDB_PORTS; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s[i] && (rank_s[i] == p)) begin
                    cdb_d[p]          = bus.req_pkt[i];
                    cdb_d[p].is_valid = 1'b1;
                end else begin
                    cdb_d[p] = cdb_d[p];
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i] && (pos_s[i] > last_pos_s)) begin
                last_pos_s = pos_s[i];
                rr_ptr_d   = (i == NUM_REQ - 1) ? {PTR_W{1'b0}} : PTR_W'(i + 1);
            end else begin
                rr_ptr_d = rr_ptr_d;
            end
        end
    end

    // Pointer and broadcast register; without grants (incl. flush) the
    // register loads all-zero and the pointer holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= {PTR_W{1'b0}};
            cdb_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.cdb_pkt   = cdb_q;
    assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed vectors with hand-computed expectations for reset, full load,
// single request, wrap-around, flush and reset-over-flush, followed by a
// random phase checked against a bench round-robin model and a packet
// scoreboard (requester 0 always valid).
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int CDB_PORTS = 2;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [1:0] rr_ptr_o;

    cdb_arbiter_if #(
        .NUM_REQ(NUM_REQ), .CDB_PORTS(CDB_PORTS),
        .TAG_WIDTH(TAG_W), .CPU_DATA_BITS(DATA_W)
    ) bus ();

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ), .CDB_PORTS(CDB_PORTS),
        .TAG_WIDTH(TAG_W), .CPU_DATA_BITS(DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .rr_ptr_o (rr_ptr_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [5:0] tag, input logic [31:0] res,
                           input logic exc);
        bus.req_pkt[i].is_valid     = 1'b0;
        bus.req_pkt[i].dest_tag     = tag;
        bus.req_pkt[i].result       = res;
        bus.req_pkt[i].is_exception = exc;
    endtask

    // Random-phase model state
    int          mptr;
    int          serial;
    int          n;
    int          last;
    int          max_wait;
    int          n_grant;
    int          n_seen;
    int          waitc [NUM_REQ];
    logic [31:0] ser   [NUM_REQ];
    logic [3:0]  pend;
    logic [3:0]  mrdy;
    logic        ev    [CDB_PORTS];
    logic [31:0] er    [CDB_PORTS];

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_pkt   = '0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_pkt(i, 6'(i + 1), 32'(100 + i), 1'b0);

        // Reset held for two cycles with every requester valid
        #1;
        chk("rst_ready", bus.req_ready, 4'b0000);
        tick();
        tick();
        chk("rst_ready2", bus.req_ready, 4'b0000);
        chk("rst_v0", bus.cdb_pkt[0].is_valid, 1'b0);
        chk("rst_v1", bus.cdb_pkt[1].is_valid, 1'b0);
        chk("rst_ptr", rr_ptr_o, 2'd0);

        // Full load: first cycle out of reset scans from 0
        rst_n = 1'b1;
        #1;
        chk("full_rdy0", bus.req_ready, 4'b0011);
        tick();
        chk("full_tag0", bus.cdb_pkt[0].dest_tag, 6'd1);
        chk("full_tag1", bus.cdb_pkt[1].dest_tag, 6'd2);
        chk("full_val", {bus.cdb_pkt[1].is_valid, bus.cdb_pkt[0].is_valid}, 2'b11);
        chk("full_res0", bus.cdb_pkt[0].result, 32'd100);
        chk("full_ptr1", rr_ptr_o, 2'd2);
        bus.req_valid = 4'b1100;
        #1;
        chk("full_rdy1", bus.req_ready, 4'b1100);
        tick();
        chk("full_tag2", bus.cdb_pkt[0].dest_tag, 6'd3);
        chk("full_tag3", bus.cdb_pkt[1].dest_tag, 6'd4);
        chk("full_ptr2", rr_ptr_o, 2'd0);
        bus.req_valid = 4'b0000;
        #1;
        chk("idle_rdy", bus.req_ready, 4'b0000);
        tick();
        chk("idle_v0", bus.cdb_pkt[0].is_valid, 1'b0);
        chk("idle_ptr", rr_ptr_o, 2'd0);

        // Single request from requester 3
        set_pkt(3, 6'd7, 32'hDEADBEEF, 1'b1);
        bus.req_valid = 4'b1000;
        #1;
        chk("single_rdy", bus.req_ready, 4'b1000);
        tick();
        chk("single_tag", bus.cdb_pkt[0].dest_tag, 6'd7);
        chk("single_res", bus.cdb_pkt[0].result, 32'hDEADBEEF);
        chk("single_exc", bus.cdb_pkt[0].is_exception, 1'b1);
        chk("single_v0", bus.cdb_pkt[0].is_valid, 1'b1);
        chk("single_v1", bus.cdb_pkt[1].is_valid, 1'b0);
        chk("single_ptr", rr_ptr_o, 2'd0);

        // Move pointer to 3 with a lone grant to requester 2
        set_pkt(2, 6'd2, 32'd2, 1'b0);
        bus.req_valid = 4'b0100;
        tick();
        chk("wrap_pre_ptr", rr_ptr_o, 2'd3);
        chk("wrap_pre_tag", bus.cdb_pkt[0].dest_tag, 6'd2);

        // Wrap-around: requester 3 before requester 0
        set_pkt(0, 6'd10, 32'd10, 1'b0);
        set_pkt(3, 6'd13, 32'd13, 1'b0);
        bus.req_valid = 4'b1001;
        #1;
        chk("wrap_rdy", bus.req_ready, 4'b1001);
        tick();
        chk("wrap_tag0", bus.cdb_pkt[0].dest_tag, 6'd13);
        chk("wrap_tag1", bus.cdb_pkt[1].dest_tag, 6'd10);
        chk("wrap_ptr", rr_ptr_o, 2'd1);

        // Flush: no grants, bus already loaded still shows its packet
        set_pkt(0, 6'd20, 32'd20, 1'b0);
        set_pkt(1, 6'd21, 32'd21, 1'b0);
        bus.req_valid = 4'b0011;
        flush = 1'b1;
        #1;
        chk("flush_rdy", bus.req_ready, 4'b0000);
        chk("flush_cur_tag", bus.cdb_pkt[0].dest_tag, 6'd13);
        tick();
        chk("flush_val", {bus.cdb_pkt[1].is_valid, bus.cdb_pkt[0].is_valid}, 2'b00);
        chk("flush_pkt0", bus.cdb_pkt[0], '0);
        chk("flush_ptr", rr_ptr_o, 2'd1);
        flush = 1'b0;
        #1;
        chk("postflush_rdy", bus.req_ready, 4'b0011);
        tick();
        chk("postflush_tag0", bus.cdb_pkt[0].dest_tag, 6'd21);
        chk("postflush_tag1", bus.cdb_pkt[1].dest_tag, 6'd20);
        chk("postflush_ptr", rr_ptr_o, 2'd1);

        // Reset together with flush: reset wins, pointer returns to 0
        bus.req_valid = 4'b1111;
        flush = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rstflush_rdy", bus.req_ready, 4'b0000);
        tick();
        chk("rstflush_ptr", rr_ptr_o, 2'd0);
        chk("rstflush_v0", bus.cdb_pkt[0].is_valid, 1'b0);
        rst_n = 1'b1;
        flush = 1'b0;
        bus.req_valid = 4'b0000;
        tick();

        // Random phase
        mptr     = 0;
        serial   = 0;
        max_wait = 0;
        n_grant  = 0;
        n_seen   = 0;
        pend     = 4'b0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            waitc[i] = 0;
            ser[i]   = 32'd0;
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            ev[p] = 1'b0;
            er[p] = 32'd0;
        end
        for (int c = 0; c < 1000; c++) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                chk("sb_valid", bus.cdb_pkt[p].is_valid, ev[p]);
                if (ev[p]) begin
                    chk("sb_result", bus.cdb_pkt[p].result, er[p]);
                    chk("sb_tag", bus.cdb_pkt[p].dest_tag, er[p][5:0]);
                    n_seen++;
                end
            end
            chk("rnd_ptr", rr_ptr_o, mptr);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && (i == 0 || $urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    serial++;
                    ser[i]   = serial;
                    waitc[i] = 0;
                    set_pkt(i, ser[i][5:0], ser[i], 1'($urandom_range(0, 1)));
                end
            end
            bus.req_valid = pend;
            #1;
            mrdy = 4'b0000;
            n    = 0;
            last = -1;
            for (int p = 0; p < CDB_PORTS; p++) ev[p] = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (mptr + k) % NUM_REQ;
                if (pend[j] && n < CDB_PORTS) begin
                    mrdy[j] = 1'b1;
                    ev[n]   = 1'b1;
                    er[n]   = ser[j];
                    n++;
                    last    = j;
                end
            end
            chk("rnd_ready", bus.req_ready, mrdy);
            if (last >= 0) mptr = (last + 1) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i]) begin
                    waitc[i]++;
                    if (mrdy[i]) begin
                        if (waitc[i] > max_wait) max_wait = waitc[i];
                        pend[i] = 1'b0;
                        n_grant++;
                    end
                end
            end
            tick();
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            chk("sb_final_valid", bus.cdb_pkt[p].is_valid, ev[p]);
            if (ev[p]) begin
                chk("sb_final_result", bus.cdb_pkt[p].result, er[p]);
                n_seen++;
            end
        end
        chk("fair_wait_le2", max_wait <= 2, 1'b1);
        chk("sb_count", n_seen, n_grant);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
